// File: rtl/target_box_detect_pkg.sv
// ---------------------------------------------------------------------------
// target_box_detect_pkg
// Shared video-processing parameters, also used by the Sobel stage that
// feeds the box detector.
//   IMG_H / IMG_V : active pixels per line / active lines per frame
//   COORD_W       : pixel coordinate width
//   CNT_W         : per-frame target-pixel count width
// Also holds the coordinate/count types and the box detector state encoding.
// ---------------------------------------------------------------------------
package target_box_detect_pkg;

    localparam int IMG_H   = 640;
    localparam int IMG_V   = 480;
    localparam int COORD_W = 10;
    localparam int CNT_W   = 19;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [CNT_W-1:0]   count_t;

    localparam coord_t COORD_MAX = '1;
    localparam count_t CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_LATCH
    } state_t;

endpackage

// File: rtl/target_box_detect_if.sv
// ---------------------------------------------------------------------------
// target_box_detect_if
// Binary video stream in, bounding-box result out.
//   per_frame_vsync/href/clken : frame sync, line valid, pixel strobe
//   per_img_bit                : 1 = edge/target pixel
//   box_valid                  : one-cycle pulse, result updated
//   box_found                  : last frame's pixel count reached the threshold
//   box_xmin/xmax/ymin/ymax    : inclusive bounds of the last frame
//   pix_count                  : target pixels in the last frame
// master = video source / result consumer, slave = box detector.
// ---------------------------------------------------------------------------
interface target_box_detect_if;
    import target_box_detect_pkg::*;

    logic   per_frame_vsync;
    logic   per_frame_href;
    logic   per_frame_clken;
    logic   per_img_bit;
    logic   box_valid;
    logic   box_found;
    coord_t box_xmin;
    coord_t box_xmax;
    coord_t box_ymin;
    coord_t box_ymax;
    count_t pix_count;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
        input  box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax,
               pix_count
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
        output box_valid, box_found, box_xmin, box_xmax, box_ymin, box_ymax,
               pix_count
    );

endinterface

// File: rtl/target_box_detect_xy_counter.sv
// ---------------------------------------------------------------------------
// pixel_xy_counter
// Coordinate generator for a video stream; reusable by any stage.
//   clk, rst_n  : pixel clock, async active-low reset
//   i_vs_rise   : frame start strobe (clears y)
//   i_href      : line valid (falling edge clears x, advances y)
//   i_clken     : pixel strobe (advances x while i_href=1)
//   o_x, o_y    : coordinate of the pixel currently on the bus
// Both counters saturate at the last active pixel/line instead of wrapping.
// ---------------------------------------------------------------------------
module pixel_xy_counter #(
    parameter int IMG_H = target_box_detect_pkg::IMG_H,
    parameter int IMG_V = target_box_detect_pkg::IMG_V
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_vs_rise,
    input  logic                           i_href,
    input  logic                           i_clken,
    output target_box_detect_pkg::coord_t  o_x,
    output target_box_detect_pkg::coord_t  o_y
);
    import target_box_detect_pkg::coord_t;

    localparam coord_t X_LAST = coord_t'(IMG_H - 1);
    localparam coord_t Y_LAST = coord_t'(IMG_V - 1);

    logic   r_href_d;
    coord_t r_x;
    coord_t r_y;
    logic   w_href_fall;

    assign w_href_fall = r_href_d & ~i_href;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_href_d <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            r_href_d <= i_href;

            if (w_href_fall) begin
                r_x <= '0;
            end else if (i_href && i_clken && (r_x < X_LAST)) begin
                r_x <= r_x + 1'b1;
            end

            if (i_vs_rise) begin
                r_y <= '0;
            end else if (w_href_fall && (r_y < Y_LAST)) begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    assign o_x = r_x;
    assign o_y = r_y;

endmodule

// File: rtl/target_box_detect.sv
// ---------------------------------------------------------------------------
// target_box_detect
// Accumulates the bounding box and pixel count of all target pixels in a
// binary frame and publishes them once per frame.
//   clk, rst_n : pixel clock, async active-low reset
//   vid_bus    : slave side of target_box_detect_if (video in, result out)
// Flow: a vsync rise in ACTIVE moves to LATCH; LATCH copies the accumulators
// to the outputs, pulses box_valid and restarts accumulation. The first vsync
// rise after reset only arms the block (IDLE -> ACTIVE), so a partial frame
// never produces a result. Result appears 2 cycles after the vsync rise.
// ---------------------------------------------------------------------------
module target_box_detect #(
    parameter int                            IMG_H   = target_box_detect_pkg::IMG_H,
    parameter int                            IMG_V   = target_box_detect_pkg::IMG_V,
    parameter target_box_detect_pkg::count_t MIN_PIX = 19'd64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    target_box_detect_if.slave        vid_bus
);
    import target_box_detect_pkg::coord_t;
    import target_box_detect_pkg::count_t;
    import target_box_detect_pkg::state_t;
    import target_box_detect_pkg::ST_IDLE;
    import target_box_detect_pkg::ST_ACTIVE;
    import target_box_detect_pkg::ST_LATCH;
    import target_box_detect_pkg::COORD_MAX;
    import target_box_detect_pkg::CNT_MAX;

    state_t r_state, w_state_nxt;
    logic   r_vsync_d;
    logic   w_vs_rise, w_hit, w_acc_en, w_pend_en, w_latch;
    coord_t w_x, w_y, w_px_y;

    coord_t r_acc_xmin, r_acc_xmax, r_acc_ymin, r_acc_ymax;
    count_t r_acc_cnt;
    // Target pixel that arrived together with the vsync rise: it belongs to
    // the new frame, so it is parked until LATCH restarts the accumulators.
    logic   r_pend_vld;
    coord_t r_pend_x;

    logic   r_box_valid, r_box_found;
    coord_t r_box_xmin, r_box_xmax, r_box_ymin, r_box_ymax;
    count_t r_pix_count;

    assign w_vs_rise = vid_bus.per_frame_vsync & ~r_vsync_d;
    assign w_hit     = vid_bus.per_frame_clken & vid_bus.per_img_bit;
    // A pixel on the vsync rise is line 0 of the new frame, not the old y.
    assign w_px_y    = w_vs_rise ? '0 : w_y;

    pixel_xy_counter #(
        .IMG_H (IMG_H),
        .IMG_V (IMG_V)
    ) u_xy (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_vs_rise (w_vs_rise),
        .i_href    (vid_bus.per_frame_href),
        .i_clken   (vid_bus.per_frame_clken),
        .o_x       (w_x),
        .o_y       (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_vsync_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vsync_d <= vid_bus.per_frame_vsync;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_en    = 1'b0;
        w_pend_en   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_rise) begin
                    w_state_nxt = ST_ACTIVE;
                    w_acc_en    = w_hit;
                end
            end
            ST_ACTIVE: begin
                if (w_vs_rise) begin
                    w_state_nxt = ST_LATCH;
                    w_pend_en   = w_hit;
                end else begin
                    w_acc_en    = w_hit;
                end
            end
            ST_LATCH: begin
                w_state_nxt = ST_ACTIVE;
                w_latch     = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_xmin  <= COORD_MAX;
            r_acc_xmax  <= '0;
            r_acc_ymin  <= COORD_MAX;
            r_acc_ymax  <= '0;
            r_acc_cnt   <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_x    <= '0;
            r_box_valid <= 1'b0;
            r_box_found <= 1'b0;
            r_box_xmin  <= '0;
            r_box_xmax  <= '0;
            r_box_ymin  <= '0;
            r_box_ymax  <= '0;
            r_pix_count <= '0;
        end else begin
            r_box_valid <= w_latch;
            if (w_latch) begin
                r_box_xmin  <= r_acc_xmin;
                r_box_xmax  <= r_acc_xmax;
                r_box_ymin  <= r_acc_ymin;
                r_box_ymax  <= r_acc_ymax;
                r_pix_count <= r_acc_cnt;
                r_box_found <= (r_acc_cnt >= MIN_PIX);
                // Restart the frame, seeded with the parked pixel if any.
                r_acc_xmin  <= r_pend_vld ? r_pend_x : COORD_MAX;
                r_acc_xmax  <= r_pend_vld ? r_pend_x : '0;
                r_acc_ymin  <= r_pend_vld ? '0 : COORD_MAX;
                r_acc_ymax  <= '0;
                r_acc_cnt   <= count_t'(r_pend_vld);
                r_pend_vld  <= 1'b0;
            end else if (w_pend_en) begin
                r_pend_vld  <= 1'b1;
                r_pend_x    <= w_x;
            end else if (w_acc_en) begin
                if (w_x < r_acc_xmin)    r_acc_xmin <= w_x;
                if (w_x > r_acc_xmax)    r_acc_xmax <= w_x;
                if (w_px_y < r_acc_ymin) r_acc_ymin <= w_px_y;
                if (w_px_y > r_acc_ymax) r_acc_ymax <= w_px_y;
                if (r_acc_cnt != CNT_MAX) r_acc_cnt <= r_acc_cnt + 1'b1;
            end
        end
    end

    assign vid_bus.box_valid = r_box_valid;
    assign vid_bus.box_found = r_box_found;
    assign vid_bus.box_xmin  = r_box_xmin;
    assign vid_bus.box_xmax  = r_box_xmax;
    assign vid_bus.box_ymin  = r_box_ymin;
    assign vid_bus.box_ymax  = r_box_ymax;
    assign vid_bus.pix_count = r_pix_count;

endmodule

// File: tb/tb_target_box_detect.sv
// ---------------------------------------------------------------------------
// tb_target_box_detect
// Frame-level bench for target_box_detect: a table of frames with their
// expected boxes, a scoreboard queue filled at each closing vsync rise and
// drained by a monitor on box_valid, plus hand-written start-up and
// mid-frame reset sequences.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_target_box_detect;
    import target_box_detect_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    target_box_detect_if vif();

    target_box_detect #(
        .IMG_H   (640),
        .IMG_V   (480),
        .MIN_PIX (19'd64)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vid_bus (vif)
    );

    typedef struct {
        string name;
        int    has_tgt;
        int    x0, x1, y0, y1;   // target rectangle in stimulus pixel indices
        int    n_lines;
        int    line_len;
        int    half_duty;
        int    e_xmin, e_xmax, e_ymin, e_ymax, e_cnt, e_found;
    } vec_t;

    typedef struct {
        string name;
        int    rise_cyc;
        int    xmin, xmax, ymin, ymax, cnt, found;
    } exp_t;

    localparam int N_VEC = 5;

    vec_t vecs[N_VEC];
    exp_t sb_q[$];
    exp_t last_exp;
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   hold_bad = 0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input string n, input int has, input int x0, input int x1,
                                input int y0, input int y1, input int nl, input int len,
                                input int half, input int exmin, input int exmax,
                                input int eymin, input int eymax, input int ecnt,
                                input int efound);
        vec_t v;
        v.name = n;  v.has_tgt = has;
        v.x0 = x0;   v.x1 = x1;  v.y0 = y0;  v.y1 = y1;
        v.n_lines = nl;  v.line_len = len;  v.half_duty = half;
        v.e_xmin = exmin;  v.e_xmax = exmax;  v.e_ymin = eymin;  v.e_ymax = eymax;
        v.e_cnt = ecnt;    v.e_found = efound;
        return v;
    endfunction

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.name = v.name;  e.rise_cyc = 0;
        e.xmin = v.e_xmin;  e.xmax = v.e_xmax;
        e.ymin = v.e_ymin;  e.ymax = v.e_ymax;
        e.cnt  = v.e_cnt;   e.found = v.e_found;
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.name = "reset";  e.rise_cyc = 0;
        e.xmin = 0;  e.xmax = 0;  e.ymin = 0;  e.ymax = 0;  e.cnt = 0;  e.found = 0;
        return e;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One line: len pixel strobes (every other cycle when half=1), then blanking.
    // len=0 gives an empty line that only advances y.
    task automatic drive_line(input int len, input int x0, input int x1, input int tgt,
                              input int half);
        vif.per_frame_href = 1'b1;
        if (len == 0) @(negedge clk);
        for (int x = 0; x < len; x++) begin
            vif.per_frame_clken = 1'b1;
            vif.per_img_bit     = (tgt != 0) && (x >= x0) && (x <= x1);
            @(negedge clk);
            if (half != 0) begin
                vif.per_frame_clken = 1'b0;
                vif.per_img_bit     = 1'b0;
                @(negedge clk);
            end
        end
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.per_img_bit     = 1'b0;
        idle_cycles(2);
    endtask

    task automatic drive_frame(input vec_t v);
        for (int ly = 0; ly < v.n_lines; ly++) begin
            if ((v.has_tgt != 0) && (ly >= v.y0) && (ly <= v.y1))
                drive_line(v.line_len, v.x0, v.x1, 1, v.half_duty);
            else
                drive_line(0, 0, 0, 0, 0);
        end
    endtask

    // Vsync pulse; when push=1 the frame just driven is closed and its
    // expected result enters the scoreboard stamped with the rise cycle.
    task automatic vsync_pulse(input int push, input exp_t e);
        vif.per_frame_vsync = 1'b1;
        if (push != 0) begin
            e.rise_cyc = cyc;
            sb_q.push_back(e);
        end
        idle_cycles(3);
        vif.per_frame_vsync = 1'b0;
        idle_cycles(3);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(vif.box_valid), 0);
        check({tag, "_found"}, 32'(vif.box_found), 0);
        check({tag, "_xmin"},  32'(vif.box_xmin),  0);
        check({tag, "_xmax"},  32'(vif.box_xmax),  0);
        check({tag, "_ymin"},  32'(vif.box_ymin),  0);
        check({tag, "_ymax"},  32'(vif.box_ymax),  0);
        check({tag, "_count"}, 32'(vif.pix_count), 0);
    endtask

    // Monitor: compares each box_valid against the scoreboard and checks that
    // outputs hold the last published result between pulses.
    initial begin : monitor
        exp_t e;
        last_exp = zero_exp();
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (vif.box_valid === 1'b1) begin
                    check("valid_single_cycle", 32'(prev_valid), 0);
                    check("valid_expected", (sb_q.size() != 0) ? 1 : 0, 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check({e.name, "_latency"}, cyc - e.rise_cyc, 2);
                        check({e.name, "_xmin"},  32'(vif.box_xmin),  e.xmin);
                        check({e.name, "_xmax"},  32'(vif.box_xmax),  e.xmax);
                        check({e.name, "_ymin"},  32'(vif.box_ymin),  e.ymin);
                        check({e.name, "_ymax"},  32'(vif.box_ymax),  e.ymax);
                        check({e.name, "_count"}, 32'(vif.pix_count), e.cnt);
                        check({e.name, "_found"}, 32'(vif.box_found), e.found);
                        check({e.name, "_hold_before"}, hold_bad, 0);
                        hold_bad = 0;
                        last_exp = e;
                    end
                end else begin
                    if ((32'(vif.box_xmin)  !== last_exp.xmin) ||
                        (32'(vif.box_xmax)  !== last_exp.xmax) ||
                        (32'(vif.box_ymin)  !== last_exp.ymin) ||
                        (32'(vif.box_ymax)  !== last_exp.ymax) ||
                        (32'(vif.pix_count) !== last_exp.cnt)  ||
                        (32'(vif.box_found) !== last_exp.found))
                        hold_bad++;
                end
                prev_valid = vif.box_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin : driver
        vec_t pre_rst;
        vec_t post_rst;
        exp_t dummy;

        //              name        has x0   x1   y0   y1  lines len half  xmin xmax ymin ymax cnt  found
        vecs[0] = mk("single_px",   1, 100, 100,  50,  50,  51, 101, 0,   100, 100,  50,  50,    1, 0);
        vecs[1] = mk("rect",        1, 200, 299, 100, 199, 200, 300, 0,   200, 299, 100, 199, 10000, 1);
        vecs[2] = mk("empty",       0,   0,   0,   0,   0,   3,   0, 0,  1023,   0,1023,   0,    0, 0);
        vecs[3] = mk("count_63",    1,  10,  18,  20,  26,  27,  19, 0,    10,  18,  20,  26,   63, 0);
        vecs[4] = mk("oversize",    1, 600, 699,   3,   3,   4, 700, 1,   600, 639,   3,   3,  100, 1);
        pre_rst  = mk("pre_rst",    1,  10,  19,   2,   5,   4,  20, 0,     0,   0,   0,   0,    0, 0);
        post_rst = mk("post_rst",   1,  30,  37,   1,   8,   9,  38, 0,    30,  37,   1,   8,   64, 1);
        dummy    = zero_exp();

        vif.per_frame_vsync = 1'b0;
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.per_img_bit     = 1'b0;
        rst_n = 1'b0;
        idle_cycles(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // Target pixels before the first vsync must not reach any result.
        drive_line(30, 5, 20, 1, 0);
        vsync_pulse(0, dummy);

        for (int i = 0; i < N_VEC; i++) begin
            drive_frame(vecs[i]);
            vsync_pulse(1, to_exp(vecs[i]));
        end

        // Half-drawn target, then reset in the middle of a target line.
        drive_frame(pre_rst);
        vif.per_frame_href  = 1'b1;
        vif.per_frame_clken = 1'b1;
        vif.per_img_bit     = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midframe_reset");
        last_exp = zero_exp();
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.per_img_bit     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);
        // Rest of the interrupted frame: block is disarmed, must be ignored.
        drive_line(20, 10, 19, 1, 0);
        drive_line(20, 10, 19, 1, 0);
        vsync_pulse(0, dummy);
        drive_frame(post_rst);
        vsync_pulse(1, to_exp(post_rst));

        for (int k = 0; (k < 20) && (sb_q.size() != 0); k++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        idle_cycles(10);
        check("final_hold", hold_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/target_box_detect.md
TARGET_BOX_DETECT -- requirements
Module: target_box_detect

Interface
REQ-001 Parameter IMG_H, default 640, active pixels per line; x counter saturates at IMG_H-1.
REQ-002 Parameter IMG_V, default 480, active lines per frame; y counter saturates at IMG_V-1.
REQ-003 Parameter MIN_PIX, default 19'd64, minimum target-pixel count per frame for a valid detection.
REQ-004 clk  in  1  pixel clock, same domain as the Sobel stage output.
REQ-005 rst_n  in  1  asynchronous reset, active low.
REQ-006 per_frame_vsync  in  1  frame sync from the edge-detect stage, active high.
REQ-007 per_frame_href  in  1  line-valid from the edge-detect stage, active high.
REQ-008 per_frame_clken  in  1  pixel-valid strobe, qualifies per_img_bit.
REQ-009 per_img_bit  in  1  binary pixel; 1 = edge/target pixel.
REQ-010 box_valid  out  1  one-cycle pulse: box outputs updated for the frame just ended.
REQ-011 box_found  out  1  1 when the last frame's pix_count >= MIN_PIX.
REQ-012 box_xmin, box_xmax  out  10 each  horizontal target bounds, inclusive.
REQ-013 box_ymin, box_ymax  out  10 each  vertical target bounds, inclusive.
REQ-014 pix_count  out  19  number of target pixels in the last complete frame.

Function
REQ-015 The block SHALL detect the frame boundary on the rising edge of per_frame_vsync, using a registered copy of the input.
REQ-016 The block SHALL implement states IDLE, ACTIVE, LATCH: IDLE -> ACTIVE on the first vsync rise after reset; ACTIVE -> LATCH on each subsequent vsync rise; LATCH -> ACTIVE unconditionally after one cycle.
REQ-017 In IDLE the block SHALL ignore all pixels, so a partial first frame never produces a result.
REQ-018 The x counter SHALL increment on each per_frame_clken while href=1, and SHALL clear to 0 on the href falling edge.
REQ-019 The y counter SHALL increment on each href falling edge and SHALL clear to 0 on the vsync rise.
REQ-020 For each clken with per_img_bit=1 in ACTIVE, the block SHALL update xmin/xmax/ymin/ymax with the current (x,y) and SHALL increment the pixel accumulator, saturating at 2^19-1.
REQ-021 Accumulators SHALL start each frame at xmin=ymin=1023, xmax=ymax=0, count=0.
REQ-022 In LATCH the block SHALL copy the accumulators to the box outputs, evaluate box_found, assert box_valid for exactly one cycle, and reinitialise the accumulators for the next frame.
REQ-023 When box_found=0, box outputs SHALL still carry the raw accumulator values; in particular, an empty frame yields xmin=1023, xmax=0.
REQ-024 A pixel coincident with the vsync rise SHALL belong to the new frame; the LATCH cycle SHALL count no pixel.
REQ-025 Latency SHALL be 2 clk cycles from the vsync rise to box_valid.
REQ-026 Box outputs SHALL hold their values between box_valid pulses.
REQ-027 Counters SHALL saturate rather than wrap when the input line or frame is oversized.

Reset
REQ-028 On rst_n=0 the block SHALL enter IDLE asynchronously, with box_valid=0, box_found=0, all bounds=0, pix_count=0, and counters and accumulators initialised per REQ-021.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, the first box_valid SHALL follow the second vsync rise.

Structure
REQ-030 IMG_H, IMG_V, the coordinate width (10) and the count width (19) SHALL be defined in the shared video-processing parameter package, which the Sobel stage also uses.
REQ-031 The x/y coordinate generator SHALL be one sub-module, pixel_xy_counter, reusable by other stages; the FSM and min/max logic SHALL live in the top module.

Verification
REQ-032 Bench SHALL drive a 640x480 frame with a single 1 at (100,50), followed by a vsync -> box_valid pulse; xmin=xmax=100; ymin=ymax=50; pix_count=1; box_found=0.
REQ-033 Bench SHALL drive a filled rectangle x 200..299, y 100..199 -> bounds 200/299/100/199; pix_count=10000; box_found=1.
REQ-034 Bench SHALL drive an all-zero frame -> xmin=1023, xmax=0, ymin=1023, ymax=0; pix_count=0; box_found=0.
REQ-035 Bench SHALL start pixels before the first vsync after reset -> no box_valid until the second vsync rise, and pre-vsync pixels are excluded.
REQ-036 Bench SHALL assert rst_n low mid-frame with the target half drawn -> all outputs 0 immediately, and the next result reflects only the complete post-reset frame.
REQ-037 Bench SHALL drive clken with 50% duty (the RGB565 byte pairing) and a 700-pixel line -> x saturates at 639, with no wrap and no spurious min update.
